// File: rtl/coffee_pkg.sv
// Shared types and helpers for the coffee vending controller.
package coffee_pkg;

    localparam int unsigned CREDIT_W = 5;
    localparam int unsigned COIN_W   = 4;
    localparam int unsigned TMO_W    = 10;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CHECK   = 3'd1,
        PAY     = 3'd2,
        WATER   = 3'd3,
        POWDER  = 3'd4,
        MILK    = 3'd5,
        DONE_ST = 3'd6,
        ERROR   = 3'd7
    } state_e;

    typedef enum logic [1:0] {
        DRINK_ESPRESSO   = 2'd0,
        DRINK_LATTE      = 2'd1,
        DRINK_CAPPUCCINO = 2'd2,
        DRINK_PREMIUM    = 2'd3
    } drink_e;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_SR   = 3'd1,
        ERR_SP   = 3'd2,
        ERR_SN   = 3'd3,
        ERR_DI   = 3'd4
    } err_e;

    // Registered output bundle of the controller.
    typedef struct packed {
        logic [3:0]          sel_oh;
        logic                e_sr;
        logic                e_sp;
        logic                e_sn;
        logic                e_di;
        logic                busy;
        logic                valve_w;
        logic                valve_p;
        logic                valve_k;
        logic [CREDIT_W-1:0] change;
        logic                done;
    } coffee_out_t;

    // Price table indexed by drink code.
    function automatic logic [CREDIT_W-1:0] price_of(input drink_e d);
        logic [CREDIT_W-1:0] p;
        case (d)
            DRINK_ESPRESSO:   p = 5'd1;
            DRINK_LATTE:      p = 5'd2;
            DRINK_CAPPUCCINO: p = 5'd5;
            default:          p = 5'd10;
        endcase
        return p;
    endfunction

    // Only milk drinks use the milk valve and care about the milk sensor.
    function automatic logic needs_milk(input drink_e d);
        return (d == DRINK_LATTE) || (d == DRINK_CAPPUCCINO);
    endfunction

    // Credit accumulation saturating at the top of the credit range.
    function automatic logic [CREDIT_W-1:0] sat_add(input logic [CREDIT_W-1:0] c,
                                                    input logic [COIN_W-1:0]   v);
        logic [CREDIT_W:0] s;
        s = (CREDIT_W+1)'(c) + (CREDIT_W+1)'(v);
        return s[CREDIT_W] ? {CREDIT_W{1'b1}} : s[CREDIT_W-1:0];
    endfunction

    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter with registered zero flag; times every dispense phase.
module phase_timer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             zero_q;

    // Load takes priority; otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Counter and zero flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            zero_q <= 1'b1;
        end else begin
            cnt_q  <= cnt_d;
            zero_q <= (cnt_d == '0);
        end
    end

    assign zero_o = zero_q;

endmodule

// File: rtl/coffee_controller.sv
// Coffee vending controller: order, payment, timed valve sequence, errors.
// Optional macro COIN_TIMEOUT_EN: abort payment after 1024 idle cycles in PAY.
module coffee_controller
    import coffee_pkg::*;
#(
    parameter int unsigned W_CYCLES = 50,
    parameter int unsigned P_CYCLES = 20,
    parameter int unsigned K_CYCLES = 30
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] sel_i,
    input  logic       start_i,
    input  logic       coin_i,
    input  logic [3:0] coin_val_i,
    input  logic       vl_i,
    input  logic       sr_i,
    input  logic       sp_i,
    input  logic       sn_i,
    input  logic       ack_i,
    output logic       s0_o,
    output logic       s1_o,
    output logic       s2_o,
    output logic       s3_o,
    output logic       e_sr_o,
    output logic       e_sp_o,
    output logic       e_sn_o,
    output logic       e_di_o,
    output logic       m_o,
    output logic       valve_w_o,
    output logic       valve_p_o,
    output logic       valve_k_o,
    output logic [4:0] change_o,
    output logic       done_o
);

    localparam int unsigned MAX_CYC = max3(W_CYCLES, P_CYCLES, K_CYCLES);
    localparam int unsigned TW      = $clog2(MAX_CYC + 1);

    state_e               state_q, state_d;
    drink_e               drink_q, drink_d;
    err_e                 err_q,   err_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    coffee_out_t          out_q,   out_d;

    logic                 tmr_load;
    logic [TW-1:0]        tmr_val;
    logic                 tmr_zero;

`ifdef COIN_TIMEOUT_EN
    logic [TMO_W-1:0]     tmo_q, tmo_d;
`endif

    phase_timer #(
        .CNT_W (TW)
    ) u_phase_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // State and order-context registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            drink_q  <= DRINK_ESPRESSO;
            err_q    <= ERR_NONE;
            credit_q <= '0;
        end else begin
            state_q  <= state_d;
            drink_q  <= drink_d;
            err_q    <= err_d;
            credit_q <= credit_d;
        end
    end

`ifdef COIN_TIMEOUT_EN
    // Cycles spent in PAY since the last coin.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`endif

    // Next-state logic; phase timer is loaded on entry to each dispense phase.
    always_comb begin
        state_d  = state_q;
        drink_d  = drink_q;
        err_d    = err_q;
        credit_d = credit_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
`ifdef COIN_TIMEOUT_EN
        tmo_d    = '0;
`endif
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    drink_d  = drink_e'(sel_i);
                    credit_d = '0;
                    err_d    = ERR_NONE;
                    state_d  = CHECK;
                end
            end
            CHECK: begin
                if (!sr_i) begin
                    err_d   = ERR_SR;
                    state_d = ERROR;
                end else if (!sp_i) begin
                    err_d   = ERR_SP;
                    state_d = ERROR;
                end else if (!sn_i && needs_milk(drink_q)) begin
                    err_d   = ERR_SN;
                    state_d = ERROR;
                end else begin
                    state_d = PAY;
                end
            end
            PAY: begin
                if (coin_i) begin
                    if (!vl_i) begin
                        err_d   = ERR_DI;
                        state_d = ERROR;
                    end else begin
                        credit_d = sat_add(credit_q, coin_val_i);
                        if (credit_d >= price_of(drink_q)) begin
                            state_d  = WATER;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(W_CYCLES - 1);
                        end
                    end
                end
`ifdef COIN_TIMEOUT_EN
                else if (tmo_q == {TMO_W{1'b1}}) begin
                    err_d   = ERR_DI;
                    state_d = ERROR;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
`endif
            end
            WATER: begin
                if (!sr_i) begin
                    err_d   = ERR_SR;
                    state_d = ERROR;
                end else if (tmr_zero) begin
                    state_d  = POWDER;
                    tmr_load = 1'b1;
                    tmr_val  = TW'(P_CYCLES - 1);
                end
            end
            POWDER: begin
                if (!sp_i) begin
                    err_d   = ERR_SP;
                    state_d = ERROR;
                end else if (tmr_zero) begin
                    if (needs_milk(drink_q)) begin
                        state_d  = MILK;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(K_CYCLES - 1);
                    end else begin
                        state_d = DONE_ST;
                    end
                end
            end
            MILK: begin
                if (!sn_i) begin
                    err_d   = ERR_SN;
                    state_d = ERROR;
                end else if (tmr_zero) begin
                    state_d = DONE_ST;
                end
            end
            DONE_ST: begin
                state_d = IDLE;
            end
            ERROR: begin
                if (ack_i) begin
                    credit_d = '0;
                    err_d    = ERR_NONE;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state so outputs track the state register.
    always_comb begin
        out_d         = '0;
        out_d.busy    = (state_d != IDLE);
        if (state_d != IDLE) begin
            out_d.sel_oh = 4'b0001 << drink_d;
        end
        out_d.valve_w = (state_d == WATER);
        out_d.valve_p = (state_d == POWDER);
        out_d.valve_k = (state_d == MILK);
        if (state_d == ERROR) begin
            out_d.e_sr = (err_d == ERR_SR);
            out_d.e_sp = (err_d == ERR_SP);
            out_d.e_sn = (err_d == ERR_SN);
            out_d.e_di = (err_d == ERR_DI);
        end
        if (state_d == DONE_ST) begin
            out_d.done   = 1'b1;
            out_d.change = credit_d - price_of(drink_d);
        end
    end

    // Output register; async reset drops valves at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign s0_o      = out_q.sel_oh[0];
    assign s1_o      = out_q.sel_oh[1];
    assign s2_o      = out_q.sel_oh[2];
    assign s3_o      = out_q.sel_oh[3];
    assign e_sr_o    = out_q.e_sr;
    assign e_sp_o    = out_q.e_sp;
    assign e_sn_o    = out_q.e_sn;
    assign e_di_o    = out_q.e_di;
    assign m_o       = out_q.busy;
    assign valve_w_o = out_q.valve_w;
    assign valve_p_o = out_q.valve_p;
    assign valve_k_o = out_q.valve_k;
    assign change_o  = out_q.change;
    assign done_o    = out_q.done;

endmodule

// File: doc/coffee_controller.md
COFFEE_CONTROLLER -- requirements
Module: coffee_controller

Interface
REQ-001 Parameter W_CYCLES, default 50, water-valve phase length in clock cycles (>=1).
REQ-002 Parameter P_CYCLES, default 20, powder-valve phase length in clock cycles (>=1).
REQ-003 Parameter K_CYCLES, default 30, milk-valve phase length in clock cycles (>=1).
REQ-004 CLK  input  1  single system clock; all state updates on its rising edge.
REQ-005 RST_N  input  1  asynchronous, active-low reset.
REQ-006 SEL  input  2  drink code: 0 espresso (price 1), 1 latte (price 2), 2 cappuccino (price 5), 3 premium (price 10).
REQ-007 START  input  1  one-cycle pulse that latches SEL and begins an order.
REQ-008 COIN  input  1  one-cycle coin-insert strobe.
REQ-009 COIN_VAL  input  4  coin value qualified by COIN.
REQ-010 VL  input  1  coin validity, qualified by COIN; 0 means rejected coin.
REQ-011 SR, SP, SN  input  1 each  water, powder and milk supply-OK sensors; 1 means OK.
REQ-012 ACK  input  1  one-cycle pulse that clears an error.
REQ-013 S0..S3  output  1 each  registered one-hot drink indication for the display decoder.
REQ-014 E_SR, E_SP, E_SN, E_DI  output  1 each  registered one-hot error indication; at most one is high.
REQ-015 M  output  1  busy indicator, high in every state except IDLE.
REQ-016 VALVE_W, VALVE_P, VALVE_K  output  1 each  water, powder and milk valve drives.
REQ-017 CHANGE  output  5  change owed, valid during the DONE pulse.
REQ-018 DONE  output  1  one-cycle pulse marking a completed order.

Function
REQ-019 FSM states SHALL be: IDLE, CHECK, PAY, WATER, POWDER, MILK, DONE_ST, ERROR.
REQ-020 IDLE: on START, latch SEL, clear credit, assert the matching S0..S3 bit next cycle, and go to CHECK; SEL changes outside IDLE are ignored.
REQ-021 CHECK (one cycle) SHALL go to ERROR if any sensor is low, else to PAY.
REQ-022 Error priority SHALL be SR > SP > SN; SN counts as a fault only for latte and cappuccino.
REQ-023 PAY: COIN with VL=1 adds COIN_VAL to a 5-bit credit that saturates at 31; COIN with VL=0 goes to ERROR with E_DI.
REQ-024 PAY SHALL leave for WATER on the cycle after credit >= price, including credit reached by the coin just accepted.
REQ-025 WATER, POWDER and MILK SHALL assert only their own valve for exactly W_CYCLES, P_CYCLES and K_CYCLES cycles respectively.
REQ-026 The MILK phase SHALL apply only to latte and cappuccino; other drinks go POWDER -> DONE_ST.
REQ-027 A sensor for the active phase going low SHALL abort to ERROR, with all valves low on the next cycle.
REQ-028 DONE_ST SHALL last one cycle, pulse DONE, present CHANGE = credit - price, then return to IDLE and clear S0..S3.
REQ-029 ERROR SHALL hold its E_* bit and all valves low until ACK, then clear credit and go to IDLE; credit is forfeited.
REQ-030 START outside IDLE, and COIN outside PAY, SHALL be ignored.
REQ-031 All outputs SHALL be registered; state-to-output latency is one cycle.

Reset
REQ-032 While RST_N=0: state IDLE, credit 0, phase counter 0, and every output 0.
REQ-033 Reset mid-dispense SHALL drop the valves immediately (asynchronously).

Configuration
REQ-034 With macro COIN_TIMEOUT_EN defined, PAY with no COIN for 1024 consecutive cycles SHALL go to ERROR with E_DI; without it, PAY waits indefinitely.

Structure
REQ-035 Package coffee_pkg SHALL hold the state enum, drink codes, the price table and the error-code enum.
REQ-036 Sub-module phase_timer SHALL be a loadable down-counter with a zero flag, shared by all dispense phases.

Verification
REQ-037 SEL=0, START, COIN_VAL=1 VL=1 -> WATER 50 cycles, POWDER 20 cycles, no MILK, DONE with CHANGE=0.
REQ-038 SEL=1, coins 1 then 5 -> dispense with the milk phase; DONE with CHANGE=4.
REQ-039 SEL=2, SP=0 at START -> E_SP high, valves low, held until ACK, then IDLE with M=0.
REQ-040 SEL=3, COIN with VL=0 -> E_DI; ACK -> IDLE with credit 0.
REQ-041 SR falls in cycle 10 of WATER -> VALVE_W=0 on the next cycle, E_SR=1.
REQ-042 RST_N low during POWDER -> all outputs 0 immediately; FSM in IDLE after release.
